alu_exec_stage: RTL and testbench

//  Execute stage directly downstream of alucontrol: consumes its 4-bit AluCtrl code plus two operands
//  and produces a registered result, zero flag and illegal-op flag. Sits between decode/operand-fetch
//  and memory/writeback. Uses a valid/ready handshake on both sides. A 2-entry skid buffer keeps

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_core.sv | 47 ++++
 rtl/alu_exec_stage.sv | 129 ++++++++++++
 tb/tb_alu_exec_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes (same encoding alucontrol emits) and the
// occupancy encoding of the execute-stage output buffer.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the alucontrol code and produces result,
// zero and illegal. Build option ALU_OVF_EN adds the signed overflow output.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Operation select; unknown codes give a zero result flagged illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: illegal = 1'b1;
    endcase
    // An illegal op must never look like a taken beq.
    zero = !illegal && (result == '0);
  end

`ifdef ALU_OVF_EN
  // Signed overflow from operand and result sign bits.
  always_comb begin
    ovf = 1'b0;
    if (alu_ctrl == ALU_ADD)
      ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
    else if (alu_ctrl == ALU_SUB)
      ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
  end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes on acceptance, then holds results in a
// MAIN/SKID register pair so in_ready depends only on registered state.
// Build option ALU_OVF_EN adds the registered ovf output.
//
//  state     | meaning
//  BUF_EMPTY | no result held, out_valid=0
//  BUF_ONE   | MAIN holds the presented result
//  BUF_TWO   | MAIN presented, SKID holds the next one, in_ready=0
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif
    logic [TAG_W-1:0] tag;
  } entry_t;

  buf_state_e state, state_nxt;
  entry_t     core_entry, main_q, skid_q;
  logic       accept, drain;
  logic       load_main, load_skid, main_from_skid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (core_entry.result),
    .zero     (core_entry.zero),
    .illegal  (core_entry.illegal)
`ifdef ALU_OVF_EN
    ,
    .ovf      (core_entry.ovf)
`endif
  );

  assign core_entry.tag = tag_in;

  assign in_ready  = (state != BUF_TWO) && rst_n;
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  // Next occupancy and which register captures what this cycle.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          state_nxt = BUF_ONE;
          load_main = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && !drain) begin
          state_nxt = BUF_TWO;
          load_skid = 1'b1;
        end else if (drain && !accept) begin
          state_nxt = BUF_EMPTY;
        end else if (accept && drain) begin
          load_main = 1'b1;
        end
      end
      BUF_TWO: begin
        if (drain) begin
          state_nxt      = BUF_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  // Result registers; only written on a transfer so idle operands never leak in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= core_entry;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= core_entry;
    end
  end

  assign result  = main_q.result;
  assign zero    = main_q.zero;
  assign illegal = main_q.illegal;
  assign tag_out = main_q.tag;
`ifdef ALU_OVF_EN
  assign ovf     = main_q.ovf;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_exec_stage;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam longint SMAX = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (W-1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    alu_ctrl = 4'd0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [TW-1:0] tag_in = '0;
  logic          in_ready, out_valid, zero, illegal;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_out;
`ifdef ALU_OVF_EN
  logic          ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0]  r;
    logic          z;
    logic          il;
    logic          ov;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];

  alu_exec_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .tag_out   (tag_out)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed output bundle: {out_valid, result, zero, illegal, tag_out}
  function automatic logic [W+TW+2:0] obs();
    return {out_valid, result, zero, illegal, tag_out};
  endfunction

  // Reference: arithmetic on signed 64-bit values, overflow = out of W-bit signed range.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] t);
    exp_t   e;
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.r = '0; e.il = 1'b0; e.ov = 1'b0; e.tag = t;
    case (c)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        full = sa + sb;
        e.r  = full[W-1:0];
        e.ov = (full > SMAX) || (full < SMIN);
      end
      4'b0110: begin
        full = sa - sb;
        e.r  = full[W-1:0];
        e.ov = (full > SMAX) || (full < SMIN);
      end
      4'b0111: e.r = (sa < sb) ? W'(1) : W'(0);
      default: e.il = 1'b1;
    endcase
    e.z = !e.il && (e.r == '0);
    return e;
  endfunction

  // Present one op and return at the negedge after it was accepted.
  task automatic drive_op(input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] t);
    int waited = 0;
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; tag_in = t;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({obs(), in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h, want 0", {obs(), in_ready});
    end
`ifdef ALU_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b, want 0", ovf);
    end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive_op(4'b0010, 32'd5, 32'd7, 5'd1);
    n_checks++;
    if (obs() !== {1'b1, 32'd12, 1'b0, 1'b0, 5'd1}) begin
      n_fail++;
      $display("FAIL add_5_7: got %h, want %h", obs(), {1'b1, 32'd12, 1'b0, 1'b0, 5'd1});
    end
  endtask

  task automatic test_sub_slt();
    out_ready = 1'b1;
    drive_op(4'b0110, 32'd9, 32'd9, 5'd3);
    n_checks++;
    if (obs() !== {1'b1, 32'd0, 1'b1, 1'b0, 5'd3}) begin
      n_fail++;
      $display("FAIL sub_9_9: got %h, want %h", obs(), {1'b1, 32'd0, 1'b1, 1'b0, 5'd3});
    end
    drive_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd4);
    n_checks++;
    if (obs() !== {1'b1, 32'd1, 1'b0, 1'b0, 5'd4}) begin
      n_fail++;
      $display("FAIL slt_m1_1: got %h, want %h", obs(), {1'b1, 32'd1, 1'b0, 1'b0, 5'd4});
    end
    drive_op(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd5);
    n_checks++;
    if (obs() !== {1'b1, 32'd0, 1'b1, 1'b0, 5'd5}) begin
      n_fail++;
      $display("FAIL slt_1_m1: got %h, want %h", obs(), {1'b1, 32'd0, 1'b1, 1'b0, 5'd5});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: out_valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
    drive_op(4'b0010, 32'd1, 32'd2, 5'd6);
    drive_op(4'b0001, 32'hF0, 32'h0F, 5'd7);
    n_checks++;
    if ({in_ready, obs()} !== {1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 5'd6}) begin
      n_fail++;
      $display("FAIL bp_full: got %h, want %h", {in_ready, obs()}, {1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 5'd6});
    end
    in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = 32'hFF; op_b = 32'h0F; tag_in = 5'd8;
    @(negedge clk);
    n_checks++;
    if ({in_ready, obs()} !== {1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 5'd6}) begin
      n_fail++;
      $display("FAIL bp_hold: got %h, want %h", {in_ready, obs()}, {1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 5'd6});
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, obs()} !== {1'b1, 1'b1, 32'hFF, 1'b0, 1'b0, 5'd7}) begin
      n_fail++;
      $display("FAIL bp_op2: got %h, want %h", {in_ready, obs()}, {1'b1, 1'b1, 32'hFF, 1'b0, 1'b0, 5'd7});
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (obs() !== {1'b1, 32'h0F, 1'b0, 1'b0, 5'd8}) begin
      n_fail++;
      $display("FAIL bp_op3: got %h, want %h", obs(), {1'b1, 32'h0F, 1'b0, 1'b0, 5'd8});
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive_op(4'b1111, 32'd0, 32'd0, 5'd9);
    n_checks++;
    if (obs() !== {1'b1, 32'd0, 1'b0, 1'b1, 5'd9}) begin
      n_fail++;
      $display("FAIL illegal_1111: got %h, want %h", obs(), {1'b1, 32'd0, 1'b0, 1'b1, 5'd9});
    end
    drive_op(4'b0101, 32'h1234, 32'h5678, 5'd10);
    n_checks++;
    if (obs() !== {1'b1, 32'd0, 1'b0, 1'b1, 5'd10}) begin
      n_fail++;
      $display("FAIL illegal_0101: got %h, want %h", obs(), {1'b1, 32'd0, 1'b0, 1'b1, 5'd10});
    end
    drive_op(4'b0010, 32'd0, 32'd0, 5'd11);
    n_checks++;
    if (obs() !== {1'b1, 32'd0, 1'b1, 1'b0, 5'd11}) begin
      n_fail++;
      $display("FAIL legal_after_illegal: got %h, want %h", obs(), {1'b1, 32'd0, 1'b1, 1'b0, 5'd11});
    end
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf();
    out_ready = 1'b1;
    drive_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd12);
    n_checks++;
    if ({result, ovf} !== {32'h8000_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_add_max: got r=%h ovf=%b, want r=80000000 ovf=1", result, ovf);
    end
    drive_op(4'b0110, 32'h8000_0000, 32'd1, 5'd13);
    n_checks++;
    if ({result, ovf} !== {32'h7FFF_FFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sub_min: got r=%h ovf=%b, want r=7fffffff ovf=1", result, ovf);
    end
    drive_op(4'b0010, 32'd1, 32'd1, 5'd14);
    n_checks++;
    if ({result, ovf} !== {32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_add_small: got r=%h ovf=%b, want r=2 ovf=0", result, ovf);
    end
  endtask
`endif

  task automatic test_reset_in_two();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(4'b0010, 32'd20, 32'd22, 5'd15);
    drive_op(4'b0010, 32'd30, 32'd32, 5'd16);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL two_before_reset: in_ready,out_valid=%b, want 01", {in_ready, out_valid});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_two: in_ready=%b out_valid=%b r=%h, want all 0", in_ready, out_valid, result);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_mid_reset: got %b, want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_after_reset: cycle %0d out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]    codes [8];
    logic [W-1:0]  edge_vals [4];
    logic [W-1:0]  a, b;
    logic [3:0]    c;
    logic [TW-1:0] t;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111, 4'b0101, 4'b0011};
    edge_vals = '{32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2}) begin
        n_fail++;
        $display("FAIL rnd_flags cyc %0d: valid,ready=%b%b, want %b%b", cyc, out_valid, in_ready,
                 q.size() != 0, q.size() < 2);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (obs() !== {1'b1, q[0].r, q[0].z, q[0].il, q[0].tag}) begin
          n_fail++;
          $display("FAIL rnd_data cyc %0d: got %h, want %h", cyc, obs(),
                   {1'b1, q[0].r, q[0].z, q[0].il, q[0].tag});
        end
`ifdef ALU_OVF_EN
        n_checks++;
        if (ovf !== q[0].ov) begin
          n_fail++;
          $display("FAIL rnd_ovf cyc %0d: got %b, want %b", cyc, ovf, q[0].ov);
        end
`endif
      end
      c = codes[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      t = TW'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      alu_ctrl = c; op_a = a; op_b = b; tag_in = t;
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(c, a, b, t));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_final_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_backpressure();
    test_illegal();
`ifdef ALU_OVF_EN
    test_ovf();
`endif
    test_reset_in_two();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
